// File: rtl/clk_enable_ctrl_if.sv
// clk_enable_ctrl_if: request/status bundle for the clock-enable sequencer.
//   enable_req  level request for the gated clock
//   busy        activity level from the gated domain
//   force_on    keeps the clock enabled unconditionally while high
//   ce          registered clock enable to the downstream buffer
//   clk_ready   gated clock running and settled
//   state       OFF=00, START=01, RUN=10, HOLD=11
//   wake_count  number of OFF->START transitions, modulo 256
// master = requester side, slave = sequencer side.
interface clk_enable_ctrl_if;
    logic       enable_req;
    logic       busy;
    logic       force_on;
    logic       ce;
    logic       clk_ready;
    logic [1:0] state;
    logic [7:0] wake_count;

    modport master (
        output enable_req, busy, force_on,
        input  ce, clk_ready, state, wake_count
    );

    modport slave (
        input  enable_req, busy, force_on,
        output ce, clk_ready, state, wake_count
    );
endinterface

// File: rtl/clk_enable_ctrl.sv
// clk_enable_ctrl: registered, glitch-free clock-enable sequencer that drives the
// CE pin of the global clock buffer. Applies a start-up settle delay, a minimum
// on-time and an idle timeout before gating the clock off.
//   clk    ungated system clock
//   reset  synchronous, active-high reset
//   bus    clk_enable_ctrl_if.slave (requests in, ce/clk_ready/state/wake_count out)
module clk_enable_ctrl #(
    parameter int unsigned ACK_DELAY     = 2,
    parameter int unsigned ON_MIN_CYCLES = 4,
    parameter int unsigned IDLE_CYCLES   = 16,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic               clk,
    input  logic               reset,
    clk_enable_ctrl_if.slave   bus
);

    localparam logic [1:0] StOff   = 2'b00;
    localparam logic [1:0] StStart = 2'b01;
    localparam logic [1:0] StRun   = 2'b10;
    localparam logic [1:0] StHold  = 2'b11;

    localparam logic [CNT_WIDTH-1:0] CntOne   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] AckLast  = CNT_WIDTH'(ACK_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] OnMin    = CNT_WIDTH'(ON_MIN_CYCLES);
    localparam logic [CNT_WIDTH-1:0] IdleLast = CNT_WIDTH'(IDLE_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] start_cnt_q, start_cnt_d;
    logic [CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_WIDTH-1:0] idle_cnt_q, idle_cnt_d;
    logic [7:0]           wake_cnt_q, wake_cnt_d;
    logic                 ce_q, ce_d;
    logic                 ready_q, ready_d;
    logic                 active;

    always_comb begin
        active      = bus.enable_req | bus.busy | bus.force_on;
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        run_cnt_d   = run_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        wake_cnt_d  = wake_cnt_q;

        case (state_q)
            StOff: begin
                if (active) begin
                    state_d     = StStart;
                    start_cnt_d = '0;
                    wake_cnt_d  = wake_cnt_q + 8'd1;
                end
            end
            StStart: begin
                // Settle window runs to completion regardless of active.
                if (start_cnt_q == AckLast) begin
                    state_d   = StRun;
                    run_cnt_d = '0;
                end else begin
                    start_cnt_d = start_cnt_q + CntOne;
                end
            end
            StRun: begin
                if (run_cnt_q != OnMin) begin
                    run_cnt_d = run_cnt_q + CntOne;
                end
                // Compare the updated count so RUN lasts exactly ON_MIN_CYCLES cycles.
                if (!active && (run_cnt_d == OnMin)) begin
                    state_d    = StHold;
                    idle_cnt_d = '0;
                end
            end
            StHold: begin
                // run_cnt stays saturated, so re-entering RUN imposes no new minimum.
                if (active) begin
                    state_d = StRun;
                end else if (idle_cnt_q == IdleLast) begin
                    state_d = StOff;
                end else begin
                    idle_cnt_d = idle_cnt_q + CntOne;
                end
            end
            default: state_d = StOff;
        endcase

        // Outputs are decoded from the next state and registered, so the buffer
        // sees a clean flop output with no decode glitches.
        ce_d    = (state_d != StOff);
        ready_d = (state_d == StRun) || (state_d == StHold);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StOff;
            start_cnt_q <= '0;
            run_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            wake_cnt_q  <= '0;
            ce_q        <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_cnt_q <= start_cnt_d;
            run_cnt_q   <= run_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            wake_cnt_q  <= wake_cnt_d;
            ce_q        <= ce_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.ce         = ce_q;
    assign bus.clk_ready  = ready_q;
    assign bus.state      = state_q;
    assign bus.wake_count = wake_cnt_q;

endmodule

// File: doc/clk_enable_ctrl.md
Name: clk_enable_ctrl

Overview:
- Registered, glitch-free clock-enable sequencer; sits directly upstream of the global clock-enable buffer and drives its CE pin.
- Turns activity/request inputs into a single registered ce level and a clk_ready acknowledge once the gated clock domain has settled.
- Enforces a start-up delay, a minimum on-time and an idle timeout before gating the clock off.

Parameters:
ACK_DELAY, 2, cycles from ce rising to clk_ready rising (>=1)
ON_MIN_CYCLES, 4, minimum RUN cycles before idle countdown may start (>=0)
IDLE_CYCLES, 16, consecutive inactive HOLD cycles before ce falls (>=1)
CNT_WIDTH, 8, width of internal counters; all parameters < 2**CNT_WIDTH

Ports:
clk  input  1  system clock; ungated, also the clock fed to the buffer
reset  input  1  synchronous, active-high reset
enable_req  input  1  level request for the gated clock
busy  input  1  activity level from the gated domain; keeps clock alive
force_on  input  1  overrides all gating; clock stays enabled while high
ce  output  1  registered clock enable to the downstream buffer
clk_ready  output  1  gated clock running and settled
state  output  2  OFF=00, START=01, RUN=10, HOLD=11
wake_count  output  8  number of OFF->START transitions, wraps at 255->0

Behaviour:
- All state changes on rising clk. Reset is synchronous, active-high. Reset values: state=OFF, ce=0, clk_ready=0, wake_count=0, all internal counters=0. Reset has priority over every transition, including mid-START, RUN or HOLD. ce drops to 0 on the edge that samples reset.
- active = enable_req | busy | force_on, sampled each edge.
- ce=1 in START, RUN and HOLD; ce=0 in OFF. clk_ready=1 in RUN and HOLD only. Both are flop outputs with no combinational path from inputs. Each toggles at most once per edge.
- OFF: if active, go to START, clear start_cnt, increment wake_count. Otherwise stay.
- START: start_cnt increments each cycle. When start_cnt==ACK_DELAY-1, go to RUN and clear run_cnt. START is never aborted; dropping active here does not shorten it.
- RUN: run_cnt increments and saturates at ON_MIN_CYCLES. If !active and run_cnt==ON_MIN_CYCLES, go to HOLD and clear idle_cnt. Otherwise stay.
- HOLD: if active, go back to RUN. run_cnt is kept, so no new minimum applies. If !active, idle_cnt increments. When idle_cnt==IDLE_CYCLES-1 and !active, go to OFF.
- Latency:
  - Request sampled at edge N gives ce=1 after N and clk_ready=1 after N+ACK_DELAY.
  - A 1-cycle request pulse gives a ce high time of ACK_DELAY+ON_MIN_CYCLES+IDLE_CYCLES cycles (22 at defaults).
  - clk_ready falls on the same edge as ce.
- Simultaneous events:
  - active re-asserting on the final HOLD cycle wins: go to RUN, not OFF.
  - active asserting on the same edge OFF is entered is sampled next edge: one cycle of ce=0, then START. The shortest ce low pulse is therefore 1 cycle.
- force_on held high prevents any exit from RUN/HOLD.
- Counters never wrap. wake_count wraps modulo 256.

Test Plan:
- Reset → release reset with inputs low; hold 10 cycles → ce=0, clk_ready=0, state=00, wake_count=0 throughout.
- Defaults → enable_req 1-cycle pulse at edge 5 → ce=1 edges 5–26 (22 cycles); clk_ready=1 from edge 7 until ce falls at edge 27; states 01→10→11→00; wake_count=1.
- Defaults, minimum on-time → busy held high for 30 cycles then low → ce stays 1 for the full busy window plus 16 HOLD cycles; no HOLD while busy.
- Defaults, re-activation in HOLD → drop enable_req, then pulse busy on HOLD cycle 16 → state returns to RUN (10); ce never drops; wake_count unchanged.
- Defaults, reset mid-operation → reset asserted during START and, separately, during HOLD → ce=0, clk_ready=0, state=00 on the next edge.
- Defaults, wrap and force_on → 256 request/timeout cycles → wake_count wraps to 0. force_on high for 100 cycles with other inputs low → ce stays 1; ce falls IDLE_CYCLES cycles after force_on drops.
